// File: rtl/cycle_hist_mon_if.sv
// Signal bundle between a monitored stream's control logic and one cycle_hist_mon
// instance: control strobes in, interval statistics and histogram out.
interface cycle_hist_mon_if #(
  parameter int unsigned CNT_SIZE = 16,
  parameter int unsigned BINS     = 16
);
  logic                enable;
  logic                clear;
  logic                event_strb;
  logic [15:0]         cycle_cnt;
  logic [CNT_SIZE-1:0] mon_cnts [BINS];
  logic [15:0]         max_interval;
  logic [31:0]         total_events;
  logic                hist_sat;

  modport master (
    output enable, clear, event_strb,
    input  cycle_cnt, mon_cnts, max_interval, total_events, hist_sat
  );

  modport slave (
    input  enable, clear, event_strb,
    output cycle_cnt, mon_cnts, max_interval, total_events, hist_sat
  );
endinterface

// File: rtl/cycle_hist_mon.sv
// Event interval monitor: measures cycles between accepted strobes and bins each
// interval into a saturating histogram through a two-stage pipeline.
module cycle_hist_mon #(
  parameter int unsigned CNT_RANGE     = 8,
  parameter int unsigned CNT_SIZE      = 16,
  parameter int unsigned MAX_CYCLE_CNT = 128
) (
  input  logic            clk,
  input  logic            reset,
  cycle_hist_mon_if.slave mon
);
  localparam int unsigned BINS  = MAX_CYCLE_CNT / CNT_RANGE;
  localparam int unsigned SHIFT = $clog2(CNT_RANGE);
  localparam int unsigned BIN_W = $clog2(BINS);

  if (CNT_RANGE == 0 || (CNT_RANGE & (CNT_RANGE - 1)) != 0) begin : g_chk_range
    $error("cycle_hist_mon: CNT_RANGE must be a power of two");
  end
  if (BINS < 2 || (BINS & (BINS - 1)) != 0) begin : g_chk_bins
    $error("cycle_hist_mon: MAX_CYCLE_CNT/CNT_RANGE must be a power of two >= 2");
  end

  logic [15:0]         r_gap;
  logic                r_armed;
  logic                r_s1_valid;
  logic [BIN_W-1:0]    r_s1_bin;
  logic [15:0]         r_cycle_cnt;
  logic [15:0]         r_max_interval;
  logic [31:0]         r_total_events;
  logic [CNT_SIZE-1:0] r_bins [BINS];
  logic                r_hist_sat;

  logic                w_accept;
  logic                w_record;
  logic [15:0]         w_interval;
  logic [BIN_W-1:0]    w_bin;

  always_comb begin
    w_accept   = mon.event_strb && mon.enable && !mon.clear;
    w_record   = w_accept && r_armed;
    w_interval = (r_gap == 16'hFFFF) ? 16'hFFFF : r_gap + 16'd1;
    // Everything at or beyond the binned range collapses into the top bin.
    if (32'(w_interval) >= MAX_CYCLE_CNT) w_bin = BIN_W'(BINS - 1);
    else                                  w_bin = BIN_W'(w_interval >> SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset || mon.clear) begin
      r_gap          <= '0;
      r_armed        <= 1'b0;
      r_s1_valid     <= 1'b0;
      r_s1_bin       <= '0;
      r_cycle_cnt    <= '0;
      r_max_interval <= '0;
      r_total_events <= '0;
      r_hist_sat     <= 1'b0;
      for (int unsigned i = 0; i < BINS; i++) r_bins[i] <= '0;
    end else begin
      if (!mon.enable)        r_gap <= '0;
      else if (w_accept)      r_gap <= '0;
      else if (r_gap != '1)   r_gap <= r_gap + 16'd1;

      if (!mon.enable)        r_armed <= 1'b0;
      else if (w_accept)      r_armed <= 1'b1;

      // Stage 1: register interval statistics and the target bin.
      r_s1_valid <= w_record;
      if (w_record) begin
        r_cycle_cnt <= w_interval;
        r_s1_bin    <= w_bin;
        if (w_interval > r_max_interval) r_max_interval <= w_interval;
        if (r_total_events != '1)        r_total_events <= r_total_events + 32'd1;
      end

      // Stage 2: saturating read-modify-write of the selected bin.
      if (r_s1_valid) begin
        if (r_bins[r_s1_bin] == '1) r_hist_sat <= 1'b1;
        else                        r_bins[r_s1_bin] <= r_bins[r_s1_bin] + 1'b1;
      end
    end
  end

  assign mon.cycle_cnt    = r_cycle_cnt;
  assign mon.max_interval = r_max_interval;
  assign mon.total_events = r_total_events;
  assign mon.hist_sat     = r_hist_sat;
  assign mon.mon_cnts     = r_bins;
endmodule

// File: tb/tb_cycle_hist_mon.sv
// Scoreboard bench for cycle_hist_mon: stimulus queues time-stamped expectations,
// a negedge monitor pops and compares them against the two DUT instances.
module tb_cycle_hist_mon;
  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  localparam int S_CYC  = 0;
  localparam int S_MAX  = 1;
  localparam int S_TOT  = 2;
  localparam int S_SAT  = 3;
  localparam int S_BIN  = 4;
  localparam int S_BCYC = 5;
  localparam int S_BSAT = 6;
  localparam int S_BBIN = 7;

  typedef struct {
    int unsigned at_cyc;
    int          sel;
    logic [3:0]  idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  cycle_hist_mon_if #(.CNT_SIZE(16), .BINS(16)) ifa ();
  cycle_hist_mon_if #(.CNT_SIZE(4),  .BINS(16)) ifb ();

  cycle_hist_mon #(.CNT_RANGE(8), .CNT_SIZE(16), .MAX_CYCLE_CNT(128)) u_dut_a (
    .clk(clk), .reset(reset), .mon(ifa)
  );
  cycle_hist_mon #(.CNT_RANGE(8), .CNT_SIZE(4), .MAX_CYCLE_CNT(128)) u_dut_b (
    .clk(clk), .reset(reset), .mon(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] read_out(input int sel, input logic [3:0] idx);
    case (sel)
      S_CYC:   return 32'(ifa.cycle_cnt);
      S_MAX:   return 32'(ifa.max_interval);
      S_TOT:   return ifa.total_events;
      S_SAT:   return 32'(ifa.hist_sat);
      S_BIN:   return 32'(ifa.mon_cnts[idx]);
      S_BCYC:  return 32'(ifb.cycle_cnt);
      S_BSAT:  return 32'(ifb.hist_sat);
      S_BBIN:  return 32'(ifb.mon_cnts[idx]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_exp(input int unsigned at, input int sel, input logic [3:0] idx,
                          input logic [31:0] v, input string nm);
    exp_t e;
    int unsigned pos;
    e.at_cyc = at; e.sel = sel; e.idx = idx; e.exp = v; e.name = nm;
    pos = sb_q.size();
    while (pos > 0 && sb_q[pos-1].at_cyc > at) pos--;
    sb_q.insert(pos, e);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].at_cyc <= cyc) begin
        e   = sb_q.pop_front();
        act = read_out(e.sel, e.idx);
        n_checks++;
        if (e.at_cyc != cyc || act !== e.exp) begin
          n_fail++;
          $display("FAIL %s [%0d] @cyc %0d (due %0d): got %0d, expected %0d",
                   e.name, e.idx, cyc, e.at_cyc, act, e.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic pulse_a(output int unsigned t);
    t = cyc;
    ifa.event_strb = 1'b1;
    step();
    ifa.event_strb = 1'b0;
  endtask

  task automatic pulse_b(output int unsigned t);
    t = cyc;
    ifb.event_strb = 1'b1;
    step();
    ifb.event_strb = 1'b0;
  endtask

  initial begin
    int unsigned t, c;
    reset = 1'b1;
    ifa.enable = 1'b0; ifa.clear = 1'b0; ifa.event_strb = 1'b0;
    ifb.enable = 1'b0; ifb.clear = 1'b0; ifb.event_strb = 1'b0;
    idle(3);

    // Reset state
    push_exp(cyc, S_CYC, 0, 0, "rst_cycle_cnt");
    push_exp(cyc, S_MAX, 0, 0, "rst_max");
    push_exp(cyc, S_TOT, 0, 0, "rst_total");
    push_exp(cyc, S_SAT, 0, 0, "rst_sat");
    for (int i = 0; i < 16; i++) push_exp(cyc, S_BIN, 4'(i), 0, "rst_bin");
    push_exp(cyc, S_BSAT, 0, 0, "rst_b_sat");
    reset = 1'b0;
    ifa.enable = 1'b1;
    idle(2);

    // Test 1: strobes at t, t+1, t+6
    pulse_a(t);
    pulse_a(t);
    push_exp(t + 1, S_CYC, 0, 1, "t1_cyc1");
    push_exp(t + 1, S_TOT, 0, 1, "t1_tot1");
    push_exp(t + 1, S_MAX, 0, 1, "t1_max1");
    push_exp(t + 2, S_BIN, 0, 1, "t1_bin0_a");
    idle(4);
    pulse_a(t);
    push_exp(t + 1, S_CYC, 0, 5, "t1_cyc5");
    push_exp(t + 1, S_TOT, 0, 2, "t1_tot2");
    push_exp(t + 1, S_MAX, 0, 5, "t1_max5");
    push_exp(t + 1, S_BIN, 0, 1, "t1_bin0_lat");
    push_exp(t + 2, S_BIN, 0, 2, "t1_bin0_b");
    idle(3);

    // Test 2: re-arm via enable toggle, then spacings 8, 127, 128, 300
    ifa.enable = 1'b0; step();
    ifa.enable = 1'b1; step();
    pulse_a(t);
    idle(7);   pulse_a(t);
    push_exp(t + 1, S_CYC, 1, 8, "t2_cyc8");
    push_exp(t + 1, S_TOT, 0, 3, "t2_tot3");
    push_exp(t + 1, S_BIN, 1, 0, "t2_bin1_lat");
    push_exp(t + 2, S_BIN, 1, 1, "t2_bin1");
    idle(126); pulse_a(t);
    push_exp(t + 1, S_CYC, 0, 127, "t2_cyc127");
    push_exp(t + 1, S_BIN, 15, 0, "t2_bin15_lat");
    push_exp(t + 2, S_BIN, 15, 1, "t2_bin15_a");
    idle(127); pulse_a(t);
    push_exp(t + 1, S_MAX, 0, 128, "t2_max128");
    push_exp(t + 2, S_BIN, 15, 2, "t2_bin15_b");
    idle(299); pulse_a(t);
    push_exp(t + 1, S_CYC, 0, 300, "t2_cyc300");
    push_exp(t + 1, S_MAX, 0, 300, "t2_max300");
    push_exp(t + 1, S_TOT, 0, 6, "t2_tot6");
    push_exp(t + 1, S_BIN, 15, 2, "t2_bin15_lat");
    push_exp(t + 2, S_BIN, 15, 3, "t2_bin15_c");
    push_exp(t + 2, S_BIN, 1, 1, "t2_bin1_final");
    push_exp(t + 2, S_BIN, 0, 2, "t2_bin0_final");

    // Test 3a: 70000-cycle interval saturates
    idle(69999); pulse_a(t);
    push_exp(t + 1, S_CYC, 0, 32'hFFFF, "t3_cyc_sat");
    push_exp(t + 1, S_MAX, 0, 32'hFFFF, "t3_max_sat");
    push_exp(t + 1, S_TOT, 0, 7, "t3_tot7");
    push_exp(t + 2, S_BIN, 15, 4, "t3_bin15");
    push_exp(t + 2, S_SAT, 0, 0, "t3_sat_a");

    // Test 3b: 4-bit bins, 16 intervals of 10
    ifb.enable = 1'b1; step();
    pulse_b(t);
    for (int k = 1; k <= 16; k++) begin
      idle(9); pulse_b(t);
      if (k == 15) begin
        push_exp(t + 2, S_BBIN, 1, 15, "t3b_bin1_15");
        push_exp(t + 2, S_BSAT, 0, 0, "t3b_sat_pre");
      end
    end
    push_exp(t + 1, S_BCYC, 0, 10, "t3b_cyc10");
    push_exp(t + 1, S_BSAT, 0, 0, "t3b_sat_lat");
    push_exp(t + 2, S_BBIN, 1, 15, "t3b_bin1_hold");
    push_exp(t + 2, S_BSAT, 0, 1, "t3b_sat");
    ifb.enable = 1'b0;
    idle(2);

    // Test 4a: clear with a strobe in the same cycle
    c = cyc;
    ifa.event_strb = 1'b1; ifa.clear = 1'b1;
    step();
    ifa.event_strb = 1'b0; ifa.clear = 1'b0;
    push_exp(c + 1, S_CYC, 0, 0, "t4_cyc0");
    push_exp(c + 1, S_MAX, 0, 0, "t4_max0");
    push_exp(c + 1, S_TOT, 0, 0, "t4_tot0");
    push_exp(c + 1, S_BIN, 0, 0, "t4_bin0");
    push_exp(c + 1, S_BIN, 15, 0, "t4_bin15");
    push_exp(c + 2, S_BIN, 15, 0, "t4_bin15_next");
    // Test 4b: clear one cycle after a recorded strobe
    pulse_a(t);
    idle(4); pulse_a(t);
    push_exp(t + 1, S_CYC, 0, 5, "t4b_cyc5");
    push_exp(t + 1, S_TOT, 0, 1, "t4b_tot1");
    ifa.clear = 1'b1; step(); ifa.clear = 1'b0;
    push_exp(t + 2, S_CYC, 0, 0, "t4b_cyc0");
    push_exp(t + 2, S_TOT, 0, 0, "t4b_tot0");
    push_exp(t + 2, S_BIN, 0, 0, "t4b_bin0");
    push_exp(t + 3, S_BIN, 0, 0, "t4b_bin0_next");
    idle(1);
    pulse_a(t);
    push_exp(t + 1, S_TOT, 0, 0, "t4c_arm_only");
    push_exp(t + 2, S_BIN, 0, 0, "t4c_bin0_arm");
    idle(5); pulse_a(t);
    push_exp(t + 1, S_CYC, 0, 6, "t4c_cyc6");
    push_exp(t + 1, S_TOT, 0, 1, "t4c_tot1");
    push_exp(t + 2, S_BIN, 0, 1, "t4c_bin0");

    // Test 5: enable drop / raise
    idle(3); pulse_a(t);
    push_exp(t + 1, S_TOT, 0, 2, "t5_tot2");
    push_exp(t + 2, S_BIN, 0, 2, "t5_bin0_2");
    idle(2);
    ifa.enable = 1'b0;
    idle(50);
    ifa.enable = 1'b1;
    pulse_a(t);
    push_exp(t + 1, S_TOT, 0, 2, "t5_arm_only");
    push_exp(t + 1, S_CYC, 0, 4, "t5_cyc_kept");
    push_exp(t + 1, S_MAX, 0, 6, "t5_max_kept");
    idle(3); pulse_a(t);
    push_exp(t + 1, S_CYC, 0, 4, "t5_cyc4");
    push_exp(t + 1, S_TOT, 0, 3, "t5_tot3");
    push_exp(t + 1, S_MAX, 0, 6, "t5_max6");
    push_exp(t + 2, S_BIN, 0, 3, "t5_bin0_3");

    // Test 6: reset during the stage-2 update
    idle(2); pulse_a(t);
    push_exp(t + 1, S_CYC, 0, 3, "t6_cyc3");
    push_exp(t + 1, S_TOT, 0, 4, "t6_tot4");
    reset = 1'b1; step(); reset = 1'b0;
    push_exp(t + 2, S_CYC, 0, 0, "t6_cyc0");
    push_exp(t + 2, S_MAX, 0, 0, "t6_max0");
    push_exp(t + 2, S_TOT, 0, 0, "t6_tot0");
    push_exp(t + 2, S_BIN, 0, 0, "t6_bin0");
    push_exp(t + 2, S_BBIN, 1, 0, "t6_b_bin1");
    push_exp(t + 2, S_BSAT, 0, 0, "t6_b_sat");
    push_exp(t + 3, S_BIN, 0, 0, "t6_bin0_next");

    idle(4);

    n_checks++;
    if (ifa.cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL final_cyc: got %0d, expected 0", ifa.cycle_cnt);
    end
    n_checks++;
    if (ifa.max_interval !== 16'd0) begin
      n_fail++;
      $display("FAIL final_max: got %0d, expected 0", ifa.max_interval);
    end
    n_checks++;
    if (ifa.total_events !== 32'd0) begin
      n_fail++;
      $display("FAIL final_tot: got %0d, expected 0", ifa.total_events);
    end
    n_checks++;
    if (ifa.hist_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL final_sat: got %0d, expected 0", ifa.hist_sat);
    end
    n_checks++;
    if (ifa.mon_cnts[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL final_bin0: got %0d, expected 0", ifa.mon_cnts[0]);
    end
    n_checks++;
    if (ifa.mon_cnts[15] !== 16'd0) begin
      n_fail++;
      $display("FAIL final_bin15: got %0d, expected 0", ifa.mon_cnts[15]);
    end
    n_checks++;
    if (ifb.hist_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL final_b_sat: got %0d, expected 0", ifb.hist_sat);
    end
    n_checks++;
    if (ifb.mon_cnts[1] !== 4'd0) begin
      n_fail++;
      $display("FAIL final_b_bin1: got %0d, expected 0", ifb.mon_cnts[1]);
    end

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never compared, expected %0d at cycle %0d", e.name, e.exp, e.at_cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
